// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshakes (fetch and data side) and the shared memory command port.
// The master view belongs to the arbiter; the slave view is the surrounding environment.
interface mem_port_arbiter_if #(
    parameter int NBITS = 8
);
    logic             f_req;
    logic [NBITS-1:0] f_addr;
    logic             f_done;
    logic [NBITS-1:0] f_rdata;
    logic             d_req;
    logic             d_we;
    logic [NBITS-1:0] d_addr;
    logic [NBITS-1:0] d_wdata;
    logic             d_done;
    logic [NBITS-1:0] d_rdata;
    logic             err;
    logic [NBITS-1:0] mem_addr;
    logic [NBITS-1:0] mem_wdata;
    logic             MemRead;
    logic             MemWrite;
    logic             busy;
    logic [NBITS-1:0] mem_rdata;

    modport master (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, busy, mem_rdata,
        output f_done, f_rdata, d_done, d_rdata, err, mem_addr, mem_wdata, MemRead, MemWrite
    );

    modport slave (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, busy, mem_rdata,
        input  f_done, f_rdata, d_done, d_rdata, err, mem_addr, mem_wdata, MemRead, MemWrite
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (F) and load/store (D) with
// round-robin on conflict, busy-hold of the access and a watchdog abort with err.
module mem_port_arbiter #(
    parameter int NBITS   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    mem_port_arbiter_if.master   bus
);
    localparam int   CNT_W = $clog2(TIMEOUT + 1);
    localparam logic OWN_F = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t           state_r,     state_s;
    logic             last_r,      last_s;
    logic             owner_r,     owner_s;
    logic             we_r,        we_s;
    logic             abort_r,     abort_s;
    logic [NBITS-1:0] addr_r,      addr_s;
    logic [NBITS-1:0] wdata_r,     wdata_s;
    logic [NBITS-1:0] f_rdata_r,   f_rdata_s;
    logic [NBITS-1:0] d_rdata_r,   d_rdata_s;
    logic [CNT_W-1:0] cnt_r,       cnt_s;
    logic             grant_d_s;

    logic             mem_read_r,  mem_read_s;
    logic             mem_write_r, mem_write_s;
    logic             f_done_r,    f_done_s;
    logic             d_done_r,    d_done_s;
    logic             err_r,       err_s;
    logic [NBITS-1:0] mem_addr_r,  mem_addr_s;
    logic [NBITS-1:0] mem_wdata_r, mem_wdata_s;

    // Next-state, arbitration, operand latching and read-data capture
    always_comb begin
        state_s   = state_r;
        last_s    = last_r;
        owner_s   = owner_r;
        we_s      = we_r;
        abort_s   = abort_r;
        addr_s    = addr_r;
        wdata_s   = wdata_r;
        f_rdata_s = f_rdata_r;
        d_rdata_s = d_rdata_r;
        cnt_s     = cnt_r;
        grant_d_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.f_req || bus.d_req) begin
                    // On conflict the side that was not served last wins
                    grant_d_s = bus.d_req && (!bus.f_req || (last_r == OWN_F));
                    owner_s   = grant_d_s;
                    last_s    = grant_d_s;
                    if (grant_d_s) begin
                        we_s    = bus.d_we;
                        addr_s  = bus.d_addr;
                        wdata_s = bus.d_wdata;
                    end else begin
                        we_s    = 1'b0;
                        addr_s  = bus.f_addr;
                        wdata_s = {NBITS{1'b0}};
                    end
                    cnt_s   = {CNT_W{1'b0}};
                    abort_s = 1'b0;
                    state_s = ACCESS;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                if (!bus.busy) begin
                    if (we_r) begin
                        d_rdata_s = d_rdata_r;
                    end else if (owner_r == OWN_D) begin
                        d_rdata_s = bus.mem_rdata;
                    end else begin
                        f_rdata_s = bus.mem_rdata;
                    end
                    state_s = RESP;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1'b1);
                    if (cnt_s == CNT_W'(TIMEOUT)) begin
                        abort_s = 1'b1;
                        if (we_r) begin
                            d_rdata_s = d_rdata_r;
                        end else if (owner_r == OWN_D) begin
                            d_rdata_s = {NBITS{1'b0}};
                        end else begin
                            f_rdata_s = {NBITS{1'b0}};
                        end
                        state_s = RESP;
                    end else begin
                        state_s = ACCESS;
                    end
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output values decoded from the upcoming state so every output leaves a flop
    always_comb begin
        mem_read_s  = (state_s == ACCESS) && !we_s;
        mem_write_s = (state_s == ACCESS) && we_s;
        mem_addr_s  = (state_s == ACCESS) ? addr_s  : {NBITS{1'b0}};
        mem_wdata_s = (state_s == ACCESS) ? wdata_s : {NBITS{1'b0}};
        f_done_s    = (state_s == RESP) && (owner_s == OWN_F);
        d_done_s    = (state_s == RESP) && (owner_s == OWN_D);
        err_s       = (state_s == RESP) && abort_s;
    end

    // State, latched operands and registered outputs with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= IDLE;
            last_r      <= OWN_F;
            owner_r     <= OWN_F;
            we_r        <= 1'b0;
            abort_r     <= 1'b0;
            addr_r      <= {NBITS{1'b0}};
            wdata_r     <= {NBITS{1'b0}};
            f_rdata_r   <= {NBITS{1'b0}};
            d_rdata_r   <= {NBITS{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            f_done_r    <= 1'b0;
            d_done_r    <= 1'b0;
            err_r       <= 1'b0;
            mem_addr_r  <= {NBITS{1'b0}};
            mem_wdata_r <= {NBITS{1'b0}};
        end else begin
            state_r     <= state_s;
            last_r      <= last_s;
            owner_r     <= owner_s;
            we_r        <= we_s;
            abort_r     <= abort_s;
            addr_r      <= addr_s;
            wdata_r     <= wdata_s;
            f_rdata_r   <= f_rdata_s;
            d_rdata_r   <= d_rdata_s;
            cnt_r       <= cnt_s;
            mem_read_r  <= mem_read_s;
            mem_write_r <= mem_write_s;
            f_done_r    <= f_done_s;
            d_done_r    <= d_done_s;
            err_r       <= err_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
        end
    end

    assign bus.MemRead   = mem_read_r;
    assign bus.MemWrite  = mem_write_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.f_done    = f_done_r;
    assign bus.d_done    = d_done_r;
    assign bus.err       = err_r;
    assign bus.f_rdata   = f_rdata_r;
    assign bus.d_rdata   = d_rdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level model of service order,
// latency and read data, driven with directed and randomized request batches.
module tb_mem_port_arbiter;
    localparam int NBITS   = 8;
    localparam int TIMEOUT = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    // Model state: who was served last and what each side's read data should be
    bit         model_last_d;
    logic [7:0] model_f_rdata;
    logic [7:0] model_d_rdata;

    mem_port_arbiter_if #(.NBITS(NBITS)) bus ();

    mem_port_arbiter #(.NBITS(NBITS), .TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic clear_inputs();
        bus.f_req = 1'b0; bus.f_addr = 8'h00;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 8'h00; bus.d_wdata = 8'h00;
        bus.busy = 1'b0;  bus.mem_rdata = 8'h00;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if ({bus.MemRead, bus.MemWrite, bus.f_done, bus.d_done, bus.err} !== 5'b00000) begin
            failures++; $display("FAIL reset_flags got %b exp 00000", {bus.MemRead, bus.MemWrite, bus.f_done, bus.d_done, bus.err});
        end
        checks++;
        if ({bus.mem_addr, bus.mem_wdata, bus.f_rdata, bus.d_rdata} !== 32'h0) begin
            failures++; $display("FAIL reset_buses got %h exp 0", {bus.mem_addr, bus.mem_wdata, bus.f_rdata, bus.d_rdata});
        end
        reset = 1'b0;
        model_last_d = 1'b0; model_f_rdata = 8'h00; model_d_rdata = 8'h00;
    endtask

    task automatic test_fetch_basic();
        bus.f_req = 1'b1; bus.f_addr = 8'h10; bus.busy = 1'b0; bus.mem_rdata = 8'hAB;
        @(negedge clock);
        checks++;
        if ({bus.MemRead, bus.MemWrite, bus.mem_addr} !== {1'b1, 1'b0, 8'h10}) begin
            failures++; $display("FAIL fetch_cmd got %b%b %h exp 10 10", bus.MemRead, bus.MemWrite, bus.mem_addr);
        end
        @(negedge clock);
        checks++;
        if ({bus.f_done, bus.d_done, bus.err, bus.MemRead, bus.f_rdata} !== {4'b1000, 8'hAB}) begin
            failures++; $display("FAIL fetch_done got f%b d%b e%b r%b %h exp f1 d0 e0 r0 ab",
                                 bus.f_done, bus.d_done, bus.err, bus.MemRead, bus.f_rdata);
        end
        bus.f_req = 1'b0;
        model_f_rdata = 8'hAB; model_last_d = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.f_done !== 1'b0) begin
            failures++; $display("FAIL fetch_single_pulse got %b exp 0", bus.f_done);
        end
    endtask

    // Present requests in IDLE and walk every resulting transaction to completion
    task automatic run_batch(input bit wf, input bit wd, input logic [7:0] fa,
                             input bit dwe, input logic [7:0] da, input logic [7:0] dwd,
                             input int bf, input int bd);
        bit         first_d;
        bit         s_d;
        bit         exp_we;
        int         n;
        int         bl;
        logic [7:0] rd;
        logic [7:0] exp_addr;
        bus.f_req = wf; bus.f_addr = fa;
        bus.d_req = wd; bus.d_we = dwe; bus.d_addr = da; bus.d_wdata = dwd;
        bus.busy = 1'b0;
        first_d = (wf && wd) ? !model_last_d : wd;
        n = (wf && wd) ? 2 : 1;
        for (int k = 0; k < n; k++) begin
            s_d      = (k == 0) ? first_d : !first_d;
            bl       = s_d ? bd : bf;
            rd       = 8'($urandom);
            exp_addr = s_d ? da : fa;
            exp_we   = s_d && dwe;
            for (int j = 1; j <= bl + 1; j++) begin
                @(negedge clock);
                checks++;
                if ({bus.MemRead, bus.MemWrite, bus.mem_addr} !== {!exp_we, exp_we, exp_addr}) begin
                    failures++; $display("FAIL access_cmd cyc%0d got rd%b wr%b a%h exp rd%b wr%b a%h", j,
                                         bus.MemRead, bus.MemWrite, bus.mem_addr, !exp_we, exp_we, exp_addr);
                end
                if (exp_we) begin
                    checks++;
                    if (bus.mem_wdata !== dwd) begin
                        failures++; $display("FAIL access_wdata got %h exp %h", bus.mem_wdata, dwd);
                    end
                end
                checks++;
                if ({bus.f_done, bus.d_done, bus.err} !== 3'b000) begin
                    failures++; $display("FAIL access_early_done got %b exp 000", {bus.f_done, bus.d_done, bus.err});
                end
                bus.busy      = (j <= bl);
                bus.mem_rdata = (j <= bl) ? 8'($urandom) : rd;
            end
            @(negedge clock);
            if (!exp_we) begin
                if (s_d) model_d_rdata = rd;
                else     model_f_rdata = rd;
            end
            model_last_d = s_d;
            checks++;
            if ({bus.f_done, bus.d_done, bus.err, bus.MemRead, bus.MemWrite} !== {!s_d, s_d, 3'b000}) begin
                failures++; $display("FAIL resp_flags got fd%b dd%b e%b r%b w%b exp fd%b dd%b 000",
                                     bus.f_done, bus.d_done, bus.err, bus.MemRead, bus.MemWrite, !s_d, s_d);
            end
            checks++;
            if ({bus.f_rdata, bus.d_rdata} !== {model_f_rdata, model_d_rdata}) begin
                failures++; $display("FAIL resp_rdata got f%h d%h exp f%h d%h",
                                     bus.f_rdata, bus.d_rdata, model_f_rdata, model_d_rdata);
            end
            if (s_d) bus.d_req = 1'b0;
            else     bus.f_req = 1'b0;
            bus.busy = 1'b0;
            @(negedge clock);
            checks++;
            if ({bus.f_done, bus.d_done, bus.err, bus.MemRead, bus.MemWrite} !== 5'b00000) begin
                failures++; $display("FAIL idle_gap got %b exp 00000",
                                     {bus.f_done, bus.d_done, bus.err, bus.MemRead, bus.MemWrite});
            end
        end
    endtask

    task automatic test_conflict();
        // D first after a fetch, then F, then D again on the next conflict
        run_batch(1'b1, 1'b1, 8'h40, 1'b0, 8'h20, 8'h00, 0, 0);
        run_batch(1'b1, 1'b1, 8'h44, 1'b0, 8'h24, 8'h00, 1, 0);
        checks++;
        if (model_last_d !== 1'b0) begin
            failures++; $display("FAIL conflict_model_order got %b exp 0", model_last_d);
        end
    endtask

    task automatic test_store_busy();
        run_batch(1'b0, 1'b1, 8'h00, 1'b1, 8'h30, 8'h5A, 0, 3);
    endtask

    task automatic test_timeout();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h77; bus.busy = 1'b1;
        for (int j = 1; j <= TIMEOUT; j++) begin
            @(negedge clock);
            checks++;
            if ({bus.MemRead, bus.d_done, bus.err} !== 3'b100) begin
                failures++; $display("FAIL timeout_hold cyc%0d got %b exp 100", j, {bus.MemRead, bus.d_done, bus.err});
            end
        end
        @(negedge clock);
        checks++;
        if ({bus.d_done, bus.err, bus.MemRead, bus.f_done, bus.d_rdata} !== {4'b1100, 8'h00}) begin
            failures++; $display("FAIL timeout_abort got dd%b e%b r%b fd%b %h exp 1100 00",
                                 bus.d_done, bus.err, bus.MemRead, bus.f_done, bus.d_rdata);
        end
        bus.d_req = 1'b0; bus.busy = 1'b0;
        model_d_rdata = 8'h00; model_last_d = 1'b1;
        @(negedge clock);
        checks++;
        if ({bus.d_done, bus.err} !== 2'b00) begin
            failures++; $display("FAIL timeout_pulse got %b exp 00", {bus.d_done, bus.err});
        end
    endtask

    task automatic test_mid_reset();
        bus.f_req = 1'b1; bus.f_addr = 8'h55; bus.busy = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if (bus.MemRead !== 1'b1) begin
            failures++; $display("FAIL midrst_pre got %b exp 1", bus.MemRead);
        end
        reset = 1'b1; bus.f_req = 1'b0;
        @(negedge clock);
        checks++;
        if ({bus.MemRead, bus.MemWrite, bus.f_done, bus.d_done, bus.err, bus.f_rdata, bus.d_rdata} !== 21'h0) begin
            failures++; $display("FAIL midrst_outputs got %h exp 0",
                                 {bus.MemRead, bus.MemWrite, bus.f_done, bus.d_done, bus.err, bus.f_rdata, bus.d_rdata});
        end
        reset = 1'b0; bus.busy = 1'b0;
        model_last_d = 1'b0; model_f_rdata = 8'h00; model_d_rdata = 8'h00;
        run_batch(1'b1, 1'b1, 8'h66, 1'b0, 8'h67, 8'h00, 0, 1);
    endtask

    task automatic test_back_to_back();
        logic [7:0] a;
        logic [7:0] r;
        a = 8'($urandom); r = 8'($urandom);
        bus.f_req = 1'b1; bus.f_addr = a; bus.mem_rdata = r; bus.busy = 1'b0; bus.d_req = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clock);
            checks++;
            if (bus.f_done !== ((c % 3) == 2)) begin
                failures++; $display("FAIL b2b_done_cadence cyc%0d got %b exp %b", c, bus.f_done, (c % 3) == 2);
            end
            if ((c % 3) == 1) begin
                checks++;
                if ({bus.MemRead, bus.mem_addr} !== {1'b1, a}) begin
                    failures++; $display("FAIL b2b_cmd cyc%0d got %b %h exp 1 %h", c, bus.MemRead, bus.mem_addr, a);
                end
            end
            if ((c % 3) == 2) begin
                checks++;
                if (bus.f_rdata !== r) begin
                    failures++; $display("FAIL b2b_rdata cyc%0d got %h exp %h", c, bus.f_rdata, r);
                end
                model_f_rdata = r;
                if (c == 14) begin
                    bus.f_req = 1'b0;
                end else begin
                    a = 8'($urandom); r = 8'($urandom);
                    bus.f_addr = a; bus.mem_rdata = r;
                end
            end
        end
        model_last_d = 1'b0;
    endtask

    task automatic test_random();
        int p;
        for (int it = 0; it < 40; it++) begin
            p = $urandom_range(1, 3);
            run_batch(p[0], p[1], 8'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                      $urandom_range(0, 4), $urandom_range(0, 4));
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_fetch_basic();
        test_conflict();
        test_store_busy();
        test_timeout();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
